character_plotter: RTL
======================

Name: character_plotter

Overview:
- Consumes the top-left coordinate produced by the character position block and rasterises the 5x9 character rectangle into the 160x120 pixel framebuffer.
- One pixel is written per clock through the VGA adapter's plot port.
- On each request it erases the previously drawn rectangle in the background colour, then draws the rectangle at the new coordinate in the character colour.
- It sits between the position logic and the VGA adapter.

Parameters:
- CHAR_W, 5, character width in pixels
- CHAR_H, 9, character height in pixels
- SCREEN_W, 160, framebuffer width; pixels with x >= SCREEN_W are suppressed
- SCREEN_H, 120, framebuffer height; pixels with y >= SCREEN_H are suppressed
- CHAR_COLOUR, 3'b111, colour used for draw pixels
- BG_COLOUR, 3'b000, colour used for erase pixels

Ports:
- Clock  in  1  system clock; one clock domain
- Reset  in  1  asynchronous, active-low reset
- XIn  in  8  top-left x of the new character position
- YIn  in  7  top-left y of the new character position
- Go  in  1  request pulse; sampled only in IDLE
- XPlot  out  8  pixel x to the VGA adapter
- YPlot  out  7  pixel y to the VGA adapter
- Colour  out  3  pixel colour
- Plot  out  1  write enable for the current XPlot/YPlot/Colour
- Busy  out  1  high whenever the state is not IDLE
- Done  out  1  one-cycle pulse when a request completes

Behaviour:
- Reset is asynchronous and active-low: Reset=0 forces the following immediately, regardless of state:
  - state to IDLE
  - XPlot=0, YPlot=0, Colour=0
  - Plot=0, Busy=0, Done=0
  - Col and Row counters to 0
  - OldX=0, OldY=0, HasDrawn=0
- A reset mid-operation abandons the request. The framebuffer may hold a partial rectangle; that is accepted.
- All outputs are registered.
- State machine states: IDLE, ERASE, DRAW, DONE.
- IDLE:
  - Go=1 at edge N latches XIn/YIn into NewX/NewY and clears Col/Row.
  - If HasDrawn=1 and (XIn,YIn) differs from (OldX,OldY), go to ERASE; otherwise go to DRAW.
  - The first request after reset always skips ERASE.
- Pixel emission (ERASE and DRAW):
  - Order is row-major: Col runs 0..CHAR_W-1 fastest, then Row runs 0..CHAR_H-1.
  - Each cycle presents base+Col / base+Row with Plot=1. Base is OldX/OldY in ERASE and NewX/NewY in DRAW.
  - Colour is BG_COLOUR in ERASE and CHAR_COLOUR in DRAW.
  - The first pixel is visible on the outputs in the cycle after edge N.
- ERASE exits to DRAW after its 45th pixel (Col=4, Row=8), with the counters cleared. There are no idle cycles between the two phases.
- DRAW exits to DONE after its 45th pixel. On that transition OldX/OldY <= NewX/NewY and HasDrawn <= 1.
- DONE lasts one cycle: Done=1, Plot=0. It then returns to IDLE.
- Plot is 0 in IDLE and DONE.
- Coordinate arithmetic:
  - x sums are computed 9 bits wide and y sums 8 bits wide.
  - If a sum is >= SCREEN_W (x) or >= SCREEN_H (y), Plot=0 for that cycle, but the cycle is still consumed.
  - XPlot/YPlot carry the truncated sum.
- Go while Busy=1 (including during DONE) is ignored and not queued.
- XIn/YIn changes after the latch cycle have no effect on the request in progress.
- Latency from Go:
  - With erase: 45 erase cycles plus 45 draw cycles; Done at cycle 91; IDLE at cycle 92, when Go is accepted again.
  - Without erase: Done at cycle 46.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE=2'd0, ERASE=2'd1, DRAW=2'd2, DONE=2'd3)
  - CHAR_W/CHAR_H, SCREEN_W/SCREEN_H
  - colour constants
  - the nine column x positions (6, 24, 42, 60, 78, 96, 114, 132, 150) and the row y of 7, so the position block and this block agree.
- One natural sub-module, rect_scanner: Col/Row counters with clear and enable, plus a last-pixel flag. The FSM instantiates it once and reuses it for both ERASE and DRAW.

Test Plan:
- Reset, then Go with XIn=78, YIn=7:
  - no erase;
  - 45 Plot pulses covering x 78..82, y 7..15 with Colour=3'b111;
  - first pixel is (78,7), last is (82,15);
  - Done pulses at cycle 46.
- Follow-up Go with XIn=96, YIn=7:
  - 45 BG pixels over x 78..82, then 45 CHAR pixels over x 96..100;
  - Done at cycle 91; Busy high for cycles 1..91.
- Repeat Go with the same XIn=96, YIn=7: ERASE is skipped; 45 draw pixels; Done at cycle 46.
- Go pulsed at cycles 10 and 60 of a busy request, and XIn changed mid-request:
  - no extra request is started;
  - the drawn rectangle uses the originally latched coordinate.
- XIn=158, YIn=115:
  - Plot=0 for pixels with x >= 160 or y >= 120;
  - exactly 2x5=10 pixels plotted;
  - Done still at cycle 46.
- Reset asserted at cycle 30 of a draw:
  - all outputs go to 0 asynchronously, before the next edge;
  - after release, the next Go skips erase (HasDrawn=0).

Source files
------------

// File: rtl/character_plotter_pkg.sv
// Shared constants and types for the character position and plotter blocks.
// Screen geometry, character cell size, colours and the fixed column grid live here.
package character_plotter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ERASE = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned CHAR_W   = 5;
    localparam int unsigned CHAR_H   = 9;
    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;

    localparam int unsigned COL_BITS = $clog2(CHAR_W);
    localparam int unsigned ROW_BITS = $clog2(CHAR_H);

    localparam logic [2:0] CHAR_COLOUR = 3'b111;
    localparam logic [2:0] BG_COLOUR   = 3'b000;

    // Column grid shared with the position block so both agree on placement
    localparam int unsigned NUM_COLS = 9;
    localparam logic [7:0] COL_X [NUM_COLS] = '{
        8'd6, 8'd24, 8'd42, 8'd60, 8'd78, 8'd96, 8'd114, 8'd132, 8'd150
    };
    localparam logic [6:0] ROW_Y = 7'd7;

    function automatic logic [7:0] column_x(input logic [3:0] idx);
        logic [7:0] x;
        x = COL_X[0];
        for (int unsigned i = 0; i < NUM_COLS; i++) begin
            if (idx == 4'(i)) begin
                x = COL_X[i];
            end
        end
        return x;
    endfunction

endpackage

// File: rtl/character_plotter_rect_scanner.sv
// Row-major column/row scanner over a W x H rectangle.
// Exposes both the registered position and the value it takes on the next edge.
module rect_scanner
    import character_plotter_pkg::*;
#(
    parameter int unsigned W  = CHAR_W,
    parameter int unsigned H  = CHAR_H,
    parameter int unsigned CW = $clog2(W),
    parameter int unsigned RW = $clog2(H)
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          Clear,
    input  logic          Enable,
    output logic [CW-1:0] Col,
    output logic [RW-1:0] Row,
    output logic [CW-1:0] ColNext,
    output logic [RW-1:0] RowNext,
    output logic          Last
);

    logic col_end;
    logic row_end;

    assign col_end = (Col == CW'(W - 1));
    assign row_end = (Row == RW'(H - 1));
    assign Last    = col_end && row_end;

    always_comb begin
        ColNext = Col;
        RowNext = Row;
        if (Clear) begin
            ColNext = '0;
            RowNext = '0;
        end else if (Enable) begin
            if (col_end) begin
                ColNext = '0;
                RowNext = row_end ? '0 : Row + RW'(1);
            end else begin
                ColNext = Col + CW'(1);
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            Col <= '0;
            Row <= '0;
        end else begin
            Col <= ColNext;
            Row <= RowNext;
        end
    end

endmodule

// File: rtl/character_plotter.sv
// Erases the previous 5x9 character cell and draws the new one, one pixel per clock.
// Outputs are registered from next-state values so the first pixel follows the Go edge.
module character_plotter
    import character_plotter_pkg::*;
(
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] XIn,
    input  logic [6:0] YIn,
    input  logic       Go,
    output logic [7:0] XPlot,
    output logic [6:0] YPlot,
    output logic [2:0] Colour,
    output logic       Plot,
    output logic       Busy,
    output logic       Done
);

    state_t state;
    state_t state_next;

    logic [7:0] new_x;
    logic [7:0] new_x_next;
    logic [6:0] new_y;
    logic [6:0] new_y_next;
    logic [7:0] old_x;
    logic [6:0] old_y;
    logic       has_drawn;

    logic                scan_clear;
    logic                scan_en;
    logic [COL_BITS-1:0] col;
    logic [ROW_BITS-1:0] row;
    logic [COL_BITS-1:0] col_next;
    logic [ROW_BITS-1:0] row_next;
    logic                last_px;

    logic [7:0] base_x;
    logic [6:0] base_y;
    logic [8:0] x_sum;
    logic [7:0] y_sum;
    logic       phase_px;
    logic       plot_next;
    logic [7:0] xplot_next;
    logic [6:0] yplot_next;
    logic [2:0] colour_next;

    rect_scanner #(
        .W (CHAR_W),
        .H (CHAR_H)
    ) u_scanner (
        .Clock   (Clock),
        .Reset   (Reset),
        .Clear   (scan_clear),
        .Enable  (scan_en),
        .Col     (col),
        .Row     (row),
        .ColNext (col_next),
        .RowNext (row_next),
        .Last    (last_px)
    );

    always_comb begin
        state_next = state;
        new_x_next = new_x;
        new_y_next = new_y;
        scan_clear = 1'b0;
        scan_en    = 1'b0;
        unique case (state)
            IDLE: begin
                if (Go) begin
                    new_x_next = XIn;
                    new_y_next = YIn;
                    scan_clear = 1'b1;
                    if (has_drawn && ((XIn != old_x) || (YIn != old_y))) begin
                        state_next = ERASE;
                    end else begin
                        state_next = DRAW;
                    end
                end
            end
            ERASE: begin
                scan_en = 1'b1;
                if (last_px) begin
                    scan_clear = 1'b1;
                    state_next = DRAW;
                end
            end
            DRAW: begin
                scan_en = 1'b1;
                if (last_px) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Pixel for the cycle after this edge, derived from where the FSM is going
    always_comb begin
        phase_px    = (state_next == ERASE) || (state_next == DRAW);
        base_x      = (state_next == ERASE) ? old_x : new_x_next;
        base_y      = (state_next == ERASE) ? old_y : new_y_next;
        x_sum       = {1'b0, base_x} + 9'(col_next);
        y_sum       = {1'b0, base_y} + 8'(row_next);
        plot_next   = phase_px && (x_sum < 9'(SCREEN_W)) && (y_sum < 8'(SCREEN_H));
        xplot_next  = phase_px ? x_sum[7:0] : '0;
        yplot_next  = phase_px ? y_sum[6:0] : '0;
        colour_next = '0;
        if (state_next == ERASE) begin
            colour_next = BG_COLOUR;
        end else if (state_next == DRAW) begin
            colour_next = CHAR_COLOUR;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            new_x     <= '0;
            new_y     <= '0;
            old_x     <= '0;
            old_y     <= '0;
            has_drawn <= 1'b0;
        end else begin
            state <= state_next;
            new_x <= new_x_next;
            new_y <= new_y_next;
            if ((state == DRAW) && last_px) begin
                old_x     <= new_x;
                old_y     <= new_y;
                has_drawn <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            XPlot  <= '0;
            YPlot  <= '0;
            Colour <= '0;
            Plot   <= 1'b0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
        end else begin
            XPlot  <= xplot_next;
            YPlot  <= yplot_next;
            Colour <= colour_next;
            Plot   <= plot_next;
            Busy   <= (state_next != IDLE);
            Done   <= (state_next == DONE);
        end
    end

endmodule
